// File: rtl/stage_mem0.sv
// MEM0 pipeline stage: latches execute results and issues one data-cache request per memory op.
// Optional misaligned-access trapping is enabled by defining MEM0_ALIGN_CHECK_EN.
package stage_mem0_pkg;
    typedef enum logic [3:0] {
        EC_IALIGN  = 4'd0,
        EC_IFAULT  = 4'd1,
        EC_ILLEGAL = 4'd2,
        EC_BREAK   = 4'd3,
        EC_LALIGN  = 4'd4,
        EC_LFAULT  = 4'd5,
        EC_SALIGN  = 4'd6,
        EC_SFAULT  = 4'd7,
        EC_ECALL   = 4'd11
    } ecause_t;
endpackage

module stage_mem0
    import stage_mem0_pkg::*;
(
    input  logic        clk_core,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic        ex_exc,
    input  ecause_t     ex_exc_cause,
    input  logic [31:2] ex_pc,
    input  logic [31:0] ex_data0,
    input  logic [31:0] ex_data1,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_extend,
    input  logic [1:0]  ex_mem_width,
    input  logic [4:0]  ex_wb_reg,
    output logic        mem0_stall,
    output logic        mem0_valid,
    output logic        mem0_exc,
    output ecause_t     mem0_exc_cause,
    output logic [31:2] mem0_pc,
    output logic [31:0] mem0_data,
    output logic        mem0_mem_read,
    output logic        mem0_mem_extend,
    output logic [1:0]  mem0_mem_width,
    output logic [1:0]  mem0_byte_off,
    output logic [4:0]  mem0_wb_reg,
    input  logic        mem1_stall,
    output logic        dc_req,
    output logic        dc_we,
    output logic [31:2] dc_addr,
    output logic [3:0]  dc_be,
    output logic [31:0] dc_wdata,
    input  logic        dc_ready,
    input  logic        csr_kill,
    input  logic        wb_exc,
    output logic        mem0_fwd_valid,
    output logic        mem0_fwd_stall,
    output logic [31:0] mem0_fwd_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ACKED = 2'd2
    } state_t;

    state_t      state;
    logic        valid;
    logic        exc;
    ecause_t     cause;
    logic [31:2] pc;
    logic [31:0] data0;
    logic [31:0] data1;
    logic        mem_read;
    logic        mem_write;
    logic        mem_extend;
    logic [1:0]  mem_width;
    logic [4:0]  wb_reg;

    logic        capture;
    logic        ex_mem;
    logic        ex_misalign;
    logic        exc_next;
    ecause_t     cause_next;
    logic [1:0]  off;

    assign ex_mem  = ex_mem_read | ex_mem_write;
    assign capture = ~mem0_stall | csr_kill;

`ifdef MEM0_ALIGN_CHECK_EN
    always_comb begin
        ex_misalign = 1'b0;
        case (ex_mem_width)
            2'd0:    ex_misalign = 1'b0;
            2'd1:    ex_misalign = ex_data0[0];
            default: ex_misalign = |ex_data0[1:0];
        endcase
    end

    assign off = data0[1:0];
`else
    assign ex_misalign = 1'b0;

    // Without trapping, misaligned low bits are simply ignored for half/word.
    always_comb begin
        off = '0;
        case (mem_width)
            2'd0:    off = data0[1:0];
            2'd1:    off = {data0[1], 1'b0};
            default: off = '0;
        endcase
    end
`endif

    assign exc_next   = ex_exc | (ex_valid & ex_mem & ex_misalign);
    assign cause_next = ex_exc ? ex_exc_cause : (ex_mem_write ? EC_SALIGN : EC_LALIGN);

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            valid <= 1'b0;
            exc   <= 1'b0;
            state <= IDLE;
        end else if (capture) begin
            valid <= ex_valid;
            exc   <= exc_next;
            state <= (ex_valid & ~exc_next & ex_mem) ? ISSUE : IDLE;
        end else if (state == ISSUE && dc_req && dc_ready) begin
            state <= ACKED;
        end
    end

    always_ff @(posedge clk_core) begin
        if (capture) begin
            cause      <= cause_next;
            pc         <= ex_pc;
            data0      <= ex_data0;
            data1      <= ex_data1;
            mem_read   <= ex_mem_read;
            mem_write  <= ex_mem_write;
            mem_extend <= ex_mem_extend;
            mem_width  <= ex_mem_width;
            wb_reg     <= ex_wb_reg;
        end
    end

    assign dc_req  = (state == ISSUE) & ~csr_kill & ~wb_exc;
    assign dc_we   = mem_write;
    assign dc_addr = data0[31:2];

    always_comb begin
        dc_be    = 4'b1111;
        dc_wdata = data1;
        case (mem_width)
            2'd0: begin
                dc_be    = 4'b0001 << off;
                dc_wdata = {4{data1[7:0]}};
            end
            2'd1: begin
                dc_be    = 4'b0011 << off;
                dc_wdata = {2{data1[15:0]}};
            end
            default: begin
                dc_be    = 4'b1111;
                dc_wdata = data1;
            end
        endcase
    end

    assign mem0_stall = (valid & (((state == ISSUE) & ~(dc_ready & dc_req)) | mem1_stall))
                      | (exc & mem1_stall);

    assign mem0_valid      = valid & ~mem0_stall & ~exc & ~csr_kill;
    assign mem0_exc        = exc & ~csr_kill;
    assign mem0_exc_cause  = cause;
    assign mem0_pc         = pc;
    assign mem0_data       = data0;
    assign mem0_mem_read   = mem_read;
    assign mem0_mem_extend = mem_extend;
    assign mem0_mem_width  = mem_width;
    assign mem0_byte_off   = off;
    assign mem0_wb_reg     = wb_reg;

    assign mem0_fwd_valid = valid & ~exc;
    assign mem0_fwd_stall = mem_read;
    assign mem0_fwd_data  = data0;

endmodule

// File: tb/tb_stage_mem0.sv
// Self-checking bench for stage_mem0: directed vector table, hand sequences for kill/reset,
// and randomized single-op transactions checked against a transaction-level model.
module tb_stage_mem0;
    import stage_mem0_pkg::*;

    logic        clk_core = 1'b0;
    logic        reset_n;
    logic        ex_valid, ex_exc;
    ecause_t     ex_exc_cause;
    logic [31:2] ex_pc;
    logic [31:0] ex_data0, ex_data1;
    logic        ex_mem_read, ex_mem_write, ex_mem_extend;
    logic [1:0]  ex_mem_width;
    logic [4:0]  ex_wb_reg;
    logic        mem0_stall, mem0_valid, mem0_exc;
    ecause_t     mem0_exc_cause;
    logic [31:2] mem0_pc;
    logic [31:0] mem0_data;
    logic        mem0_mem_read, mem0_mem_extend;
    logic [1:0]  mem0_mem_width, mem0_byte_off;
    logic [4:0]  mem0_wb_reg;
    logic        mem1_stall;
    logic        dc_req, dc_we;
    logic [31:2] dc_addr;
    logic [3:0]  dc_be;
    logic [31:0] dc_wdata;
    logic        dc_ready, csr_kill, wb_exc;
    logic        mem0_fwd_valid, mem0_fwd_stall;
    logic [31:0] mem0_fwd_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_core = ~clk_core;

    stage_mem0 dut (
        .clk_core(clk_core), .reset_n(reset_n),
        .ex_valid(ex_valid), .ex_exc(ex_exc), .ex_exc_cause(ex_exc_cause), .ex_pc(ex_pc),
        .ex_data0(ex_data0), .ex_data1(ex_data1), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_extend(ex_mem_extend),
        .ex_mem_width(ex_mem_width), .ex_wb_reg(ex_wb_reg),
        .mem0_stall(mem0_stall), .mem0_valid(mem0_valid), .mem0_exc(mem0_exc),
        .mem0_exc_cause(mem0_exc_cause), .mem0_pc(mem0_pc), .mem0_data(mem0_data),
        .mem0_mem_read(mem0_mem_read), .mem0_mem_extend(mem0_mem_extend),
        .mem0_mem_width(mem0_mem_width), .mem0_byte_off(mem0_byte_off),
        .mem0_wb_reg(mem0_wb_reg), .mem1_stall(mem1_stall),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_be(dc_be),
        .dc_wdata(dc_wdata), .dc_ready(dc_ready), .csr_kill(csr_kill), .wb_exc(wb_exc),
        .mem0_fwd_valid(mem0_fwd_valid), .mem0_fwd_stall(mem0_fwd_stall),
        .mem0_fwd_data(mem0_fwd_data)
    );

`ifdef MEM0_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic        rd, wr;
        logic [1:0]  width;
        logic [31:0] addr, data1;
        logic        exc;
        logic [3:0]  cause;
        logic [29:0] pc;
        logic [4:0]  wb;
        int unsigned rdy, m1;
    } op_t;

    typedef struct {
        int unsigned n_req, n_acc, n_stall, n_valid, n_exc;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [29:0] addr;
        logic        we;
        logic [1:0]  off;
        logic [31:0] data;
        logic [29:0] pc;
        logic [4:0]  wb;
        logic [3:0]  cause;
        logic        fwd_valid, fwd_stall;
        logic [31:0] fwd_data;
    } obs_t;

    typedef struct {
        op_t         op;
        int unsigned exp_req, exp_stall;
        logic        exp_exc;
        logic [3:0]  exp_be, exp_cause;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_exc = 0; ex_exc_cause = EC_IALIGN; ex_pc = '0;
        ex_data0 = '0; ex_data1 = '0; ex_mem_read = 0; ex_mem_write = 0;
        ex_mem_extend = 0; ex_mem_width = '0; ex_wb_reg = '0;
        mem1_stall = 0; dc_ready = 0; csr_kill = 0; wb_exc = 0;
    endtask

    // Present one op for a single capture, then run until it has left the stage.
    task automatic run_op(input op_t op, output obs_t o);
        int unsigned w;
        o = '{default: '0};
        ex_valid = 1; ex_exc = op.exc; ex_exc_cause = ecause_t'(op.cause); ex_pc = op.pc;
        ex_data0 = op.addr; ex_data1 = op.data1; ex_mem_read = op.rd; ex_mem_write = op.wr;
        ex_mem_extend = 0; ex_mem_width = op.width; ex_wb_reg = op.wb;
        dc_ready = 0; mem1_stall = 0;
        @(posedge clk_core); #1;
        ex_valid = 0; ex_exc = 0; ex_mem_read = 0; ex_mem_write = 0;
        w = umax(op.rdy, op.m1) + 2;
        for (int unsigned k = 0; k < w; k++) begin
            dc_ready   = (k >= op.rdy);
            mem1_stall = (k < op.m1);
            @(negedge clk_core);
            if (k == 0) begin
                o.off = mem0_byte_off; o.fwd_valid = mem0_fwd_valid;
                o.fwd_stall = mem0_fwd_stall; o.fwd_data = mem0_fwd_data;
            end
            if (dc_req) o.n_req++;
            if (dc_req && dc_ready) begin
                o.n_acc++; o.be = dc_be; o.wdata = dc_wdata; o.addr = dc_addr; o.we = dc_we;
            end
            if (mem0_stall) o.n_stall++;
            if (mem0_valid) begin
                o.n_valid++; o.pc = mem0_pc; o.data = mem0_data; o.wb = mem0_wb_reg;
            end
            if (mem0_exc) begin
                o.n_exc++; o.cause = mem0_exc_cause; o.data = mem0_data;
            end
            @(posedge clk_core); #1;
        end
        dc_ready = 0; mem1_stall = 0;
    endtask

    // Transaction-level expectation from the access rules.
    function automatic obs_t model(input op_t op);
        obs_t e;
        bit mem, mis, is_exc, issue;
        int unsigned a4;
        e = '{default: '0};
        a4  = op.addr % 4;
        mem = op.rd || op.wr;
        mis = ALIGN && ((op.width == 1 && (a4 % 2) != 0) || (op.width == 2 && a4 != 0));
        is_exc = op.exc || (mem && mis);
        issue  = mem && !is_exc;
        e.cause = op.exc ? op.cause : (op.wr ? 4'd6 : 4'd4);
        e.n_req   = issue ? op.rdy + 1 : 0;
        e.n_acc   = issue ? 1 : 0;
        e.n_stall = issue ? umax(op.rdy, op.m1) : op.m1;
        e.n_valid = is_exc ? 0 : 1;
        e.n_exc   = is_exc ? op.m1 + 1 : 0;
        if (ALIGN || op.width == 0) e.off = 2'(a4);
        else if (op.width == 1)     e.off = 2'((a4 / 2) * 2);
        else                        e.off = 2'd0;
        if (op.width == 0) begin
            e.be = 4'(1 << e.off); e.wdata = (op.data1 & 32'hFF) * 32'h0101_0101;
        end else if (op.width == 1) begin
            e.be = 4'(3 << e.off); e.wdata = (op.data1 & 32'hFFFF) * 32'h0001_0001;
        end else begin
            e.be = 4'hF; e.wdata = op.data1;
        end
        e.addr = op.addr[31:2]; e.we = op.wr;
        e.data = op.addr; e.pc = op.pc; e.wb = op.wb;
        e.fwd_valid = !is_exc; e.fwd_stall = op.rd; e.fwd_data = op.addr;
        return e;
    endfunction

    task automatic compare(input string t, input op_t op, input obs_t e, input obs_t o);
        chk({t, " n_req"},   o.n_req,   e.n_req);
        chk({t, " n_acc"},   o.n_acc,   e.n_acc);
        chk({t, " n_stall"}, o.n_stall, e.n_stall);
        chk({t, " n_valid"}, o.n_valid, e.n_valid);
        chk({t, " n_exc"},   o.n_exc,   e.n_exc);
        chk({t, " byte_off"}, o.off,    e.off);
        chk({t, " fwd_valid"}, o.fwd_valid, e.fwd_valid);
        chk({t, " fwd_stall"}, o.fwd_stall, e.fwd_stall);
        chk({t, " fwd_data"},  o.fwd_data,  e.fwd_data);
        if (e.n_acc != 0) begin
            chk({t, " dc_be"},   o.be,   e.be);
            chk({t, " dc_addr"}, o.addr, e.addr);
            chk({t, " dc_we"},   o.we,   e.we);
            if (op.wr) chk({t, " dc_wdata"}, o.wdata, e.wdata);
        end
        if (e.n_valid != 0) begin
            chk({t, " pc"},   o.pc,   e.pc);
            chk({t, " data"}, o.data, e.data);
            chk({t, " wb"},   o.wb,   e.wb);
        end
        if (e.n_exc != 0) begin
            chk({t, " cause"},    o.cause, e.cause);
            chk({t, " exc_data"}, o.data,  e.data);
        end
    endtask

    function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] width,
                               input logic [31:0] addr, input logic [31:0] data1,
                               input logic exc, input logic [3:0] cause,
                               input int unsigned rdy, input int unsigned m1);
        op_t op;
        op.rd = rd; op.wr = wr; op.width = width; op.addr = addr; op.data1 = data1;
        op.exc = exc; op.cause = cause; op.pc = 30'(addr + 32'h40); op.wb = 5'(addr + 1);
        op.rdy = rdy; op.m1 = m1;
        return op;
    endfunction

    vec_t vecs[8];
    obs_t o;
    op_t  op;

    initial begin
        vecs[0] = '{mk(1, 0, 2, 32'h100, 32'h0, 0, 0, 0, 0), 1, 0, 0, 4'hF, 4'h0, 32'h0};
        vecs[1] = '{mk(0, 1, 0, 32'h203, 32'hAB, 0, 0, 3, 0), 4, 3, 0, 4'h8, 4'h0, 32'hABAB_ABAB};
        vecs[2] = '{mk(1, 0, 2, 32'h40, 32'h0, 0, 0, 0, 2), 1, 2, 0, 4'hF, 4'h0, 32'h0};
`ifdef MEM0_ALIGN_CHECK_EN
        vecs[3] = '{mk(1, 0, 1, 32'h101, 32'h0, 0, 0, 0, 0), 0, 0, 1, 4'h0, 4'h4, 32'h0};
`else
        vecs[3] = '{mk(1, 0, 1, 32'h101, 32'h0, 0, 0, 0, 0), 1, 0, 0, 4'h3, 4'h0, 32'h0};
`endif
        vecs[4] = '{mk(0, 1, 1, 32'h102, 32'h1234_CDEF, 0, 0, 1, 0), 2, 1, 0, 4'hC, 4'h0, 32'hCDEF_CDEF};
        vecs[5] = '{mk(0, 1, 0, 32'h001, 32'h5A, 0, 0, 2, 4), 3, 4, 0, 4'h2, 4'h0, 32'h5A5A_5A5A};
        vecs[6] = '{mk(0, 1, 2, 32'h300, 32'hDEAD_BEEF, 0, 0, 1, 1), 2, 1, 0, 4'hF, 4'h0, 32'hDEAD_BEEF};
        vecs[7] = '{mk(0, 0, 2, 32'h777, 32'h0, 1, 2, 0, 1), 0, 1, 1, 4'h0, 4'h2, 32'h0};

        idle_inputs();
        reset_n = 0;
        repeat (2) @(posedge clk_core);
        #1 reset_n = 1;
        @(negedge clk_core);
        chk("reset dc_req", dc_req, 0);
        chk("reset mem0_valid", mem0_valid, 0);
        chk("reset mem0_exc", mem0_exc, 0);
        chk("reset mem0_stall", mem0_stall, 0);
        chk("reset fwd_valid", mem0_fwd_valid, 0);
        @(posedge clk_core); #1;

        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            run_op(vecs[i].op, o);
            chk({t, " n_req"}, o.n_req, vecs[i].exp_req);
            chk({t, " n_acc"}, o.n_acc, (vecs[i].exp_req != 0) ? 1 : 0);
            chk({t, " n_stall"}, o.n_stall, vecs[i].exp_stall);
            chk({t, " exc"}, (o.n_exc != 0), vecs[i].exp_exc);
            if (vecs[i].exp_req != 0) begin
                chk({t, " dc_be"}, o.be, vecs[i].exp_be);
                if (vecs[i].op.wr) chk({t, " dc_wdata"}, o.wdata, vecs[i].exp_wdata);
            end
            if (vecs[i].exp_exc) begin
                chk({t, " cause"}, o.cause, vecs[i].exp_cause);
                chk({t, " exc_data"}, o.data, vecs[i].op.addr);
            end
        end

        // csr_kill while a request is waiting: request drops, next entry taken at once.
        ex_valid = 1; ex_mem_read = 1; ex_mem_width = 2; ex_data0 = 32'h500; ex_pc = 30'h11;
        @(posedge clk_core); #1;
        ex_valid = 0; ex_mem_read = 0;
        @(negedge clk_core);
        chk("kill pre dc_req", dc_req, 1);
        chk("kill pre stall", mem0_stall, 1);
        @(posedge clk_core); #1;
        csr_kill = 1; ex_valid = 1; ex_pc = 30'h55; ex_data0 = 32'h1234;
        @(negedge clk_core);
        chk("kill dc_req", dc_req, 0);
        chk("kill mem0_valid", mem0_valid, 0);
        chk("kill mem0_exc", mem0_exc, 0);
        @(posedge clk_core); #1;
        csr_kill = 0; ex_valid = 0;
        @(negedge clk_core);
        chk("kill next valid", mem0_valid, 1);
        chk("kill next pc", mem0_pc, 30'h55);
        chk("kill next dc_req", dc_req, 0);
        @(posedge clk_core); #1;

        // wb_exc masks the request without releasing the stall.
        ex_valid = 1; ex_mem_write = 1; ex_mem_width = 2; ex_data0 = 32'h600;
        @(posedge clk_core); #1;
        ex_valid = 0; ex_mem_write = 0; dc_ready = 1; wb_exc = 1;
        @(negedge clk_core);
        chk("wbexc dc_req", dc_req, 0);
        chk("wbexc stall", mem0_stall, 1);
        @(posedge clk_core); #1;
        wb_exc = 0;
        @(negedge clk_core);
        chk("wbexc release dc_req", dc_req, 1);
        chk("wbexc release stall", mem0_stall, 0);
        @(posedge clk_core); #1;
        dc_ready = 0;

        // Reset while a request is pending.
        ex_valid = 1; ex_mem_read = 1; ex_data0 = 32'h700;
        @(posedge clk_core); #1;
        ex_valid = 0; ex_mem_read = 0; reset_n = 0;
        @(posedge clk_core); #1;
        reset_n = 1;
        @(negedge clk_core);
        chk("rst pend dc_req", dc_req, 0);
        chk("rst pend stall", mem0_stall, 0);
        chk("rst pend valid", mem0_valid, 0);
        @(posedge clk_core); #1;
        chk("rst pend stays idle", dc_req, 0);

        for (int n = 0; n < 150; n++) begin
            int unsigned kind;
            logic [3:0] causes [6];
            causes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7};
            kind = $urandom_range(0, 3);
            op.rd = (kind == 1); op.wr = (kind == 2); op.exc = (kind == 3);
            op.width = 2'($urandom_range(0, 2));
            op.addr = $urandom; op.data1 = $urandom;
            op.cause = causes[$urandom_range(0, 5)];
            op.pc = 30'($urandom); op.wb = 5'($urandom);
            op.rdy = $urandom_range(0, 3); op.m1 = $urandom_range(0, 3);
            run_op(op, o);
            compare($sformatf("rnd%0d", n), op, model(op), o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
